axi_cfg_master: RTL and testbench
=================================

// Module: axi_cfg_master
// PURPOSE
//  AXI4-Lite initiator driving the board-side config register slave (char_select 0x0,
//  network_output 0x4, xadc_config 0x8). Takes one-at-a-time read/write commands from a
//  local controller (test sequencer, UART bridge) and runs the full AXI handshake.
//  Returns read data and response codes. Never more than one transaction outstanding.
// PARAMETERS
//  C_M_AXI_DATA_WIDTH   32     data bus width; WSTRB width = C_M_AXI_DATA_WIDTH/8
//  C_M_AXI_ADDR_WIDTH   9      address bus width
//  TIMEOUT_CYCLES       1024   watchdog limit (used only with AXI_CFG_MASTER_TIMEOUT_EN)
// PORTS
//  clk            in   1    single clock for the block and the AXI bus
//  rst            in   1    asynchronous reset, active-high
//  cmd_valid      in   1    command offered
//  cmd_ready      out  1    command accepted when cmd_valid & cmd_ready
//  cmd_write      in   1    1 = write, 0 = read
//  cmd_addr       in   ADDR command address
//  cmd_wdata      in   DATA write data
//  cmd_wstrb      in   DATA/8  write byte strobes
//  rsp_valid      out  1    response available
//  rsp_ready      in   1    response consumed when rsp_valid & rsp_ready
//  rsp_rdata      out  DATA read data; 0 for writes
//  rsp_resp       out  2    BRESP or RRESP of the completed transaction
//  M_AXI_AWADDR/AWVALID out, AWREADY in   write address channel
//  M_AXI_WDATA/WSTRB/WVALID out, WREADY in  write data channel
//  M_AXI_BRESP/BVALID in, BREADY out     write response channel
//  M_AXI_ARADDR/ARVALID out, ARREADY in   read address channel
//  M_AXI_RDATA/RRESP/RVALID in, RREADY out  read data channel
// BEHAVIOUR
//  - Reset (async, rst=1): state IDLE; every VALID/READY output, cmd_ready, rsp_valid = 0;
//    addr/data/strb/rdata/resp registers = 0. Reset mid-transaction drops it and loses the response.
//  - All outputs registered. FSM: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, RESP.
//  - IDLE: cmd_ready=1. Accept in cycle N: latch addr/wdata/wstrb; go to WR_REQ or RD_REQ.
//    AWVALID+WVALID (write) or ARVALID (read) are high from cycle N+1.
//  - WR_REQ: AWVALID and WVALID assert together. Each drops the cycle after its own
//    READY is sampled high (independent handshakes, either order or same cycle).
//    Leave for WR_RESP once both have completed. BREADY=1 in WR_RESP.
//  - WR_RESP: on BVALID, capture BRESP into rsp_resp and set rsp_rdata=0. Go to RESP.
//  - RD_REQ: ARVALID held until ARREADY, then go to RD_DATA with RREADY=1.
//  - RD_DATA: on RVALID, capture RDATA/RRESP. Go to RESP.
//  - RESP: rsp_valid=1 and rsp_rdata/rsp_resp stable until rsp_ready. Then IDLE, cmd_ready=1
//    the next cycle. Back-to-back minimum: 4 cycles per command with a zero-wait slave.
//  - Addresses are passed unmodified; AWPROT/ARPROT are not driven (tie 0 at top).
//  - A VALID is never deasserted before its READY. Address/data are stable while VALID=1.
//  - BVALID/RVALID arriving outside their wait states are ignored (READY is low).
// CONFIGURATION
//  AXI_CFG_MASTER_TIMEOUT_EN defined:
//   - Adds output timeout_err (1 bit, reset 0).
//   - A cycle counter clears on every state change and counts in every non-IDLE, non-RESP state.
//   - At TIMEOUT_CYCLES it sets timeout_err (sticky until rst). The transaction keeps waiting,
//     so AXI stays legal.
//  Not defined: no counter, no timeout_err port; the block waits indefinitely.
// TESTING
//  1. Write 0x8 data 0xDEADBEEF strb 0xF, zero-wait slave -> AW/W valid cycle N+1;
//     rsp_resp=00, rsp_rdata=0; slave xadc_config=0xDEADBEEF.
//  2. Read 0x8 after test 1 -> rsp_rdata=0xDEADBEEF, rsp_resp=00, rsp_valid held while
//     rsp_ready=0 for 5 cycles.
//  3. Write 0x0 data 0x2: WREADY 3 cycles before AWREADY, then reversed order
//     -> each VALID drops only after its own READY; single BREADY handshake; read 0x0 returns 0x2.
//  4. Slave returns BRESP=2'b10 and RRESP=2'b10 -> rsp_resp=10 for each; no hang.
//  5. Assert rst while ARVALID high awaiting ARREADY -> all VALID/READY low immediately;
//     IDLE; cmd_ready=1 after release.
//  6. (TIMEOUT_EN, TIMEOUT_CYCLES=16) ARREADY held low 20 cycles -> timeout_err=1 at cycle 16;
//     ARVALID still high; read completes when ARREADY is later given.

Source files
------------

// File: rtl/axi_cfg_master_if.sv
// AXI4-Lite bus bundle between axi_cfg_master and the board config register slave.
// PROT signals are left out; the integrator ties AWPROT/ARPROT to zero at the top level.
interface axi_cfg_master_if #(
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int C_M_AXI_ADDR_WIDTH = 9
);
  logic [C_M_AXI_ADDR_WIDTH-1:0]   AWADDR;
  logic                            AWVALID;
  logic                            AWREADY;
  logic [C_M_AXI_DATA_WIDTH-1:0]   WDATA;
  logic [C_M_AXI_DATA_WIDTH/8-1:0] WSTRB;
  logic                            WVALID;
  logic                            WREADY;
  logic [1:0]                      BRESP;
  logic                            BVALID;
  logic                            BREADY;
  logic [C_M_AXI_ADDR_WIDTH-1:0]   ARADDR;
  logic                            ARVALID;
  logic                            ARREADY;
  logic [C_M_AXI_DATA_WIDTH-1:0]   RDATA;
  logic [1:0]                      RRESP;
  logic                            RVALID;
  logic                            RREADY;

  modport master (
    output AWADDR, AWVALID, input AWREADY,
    output WDATA, WSTRB, WVALID, input WREADY,
    input BRESP, BVALID, output BREADY,
    output ARADDR, ARVALID, input ARREADY,
    input RDATA, RRESP, RVALID, output RREADY
  );

  modport slave (
    input AWADDR, AWVALID, output AWREADY,
    input WDATA, WSTRB, WVALID, output WREADY,
    output BRESP, BVALID, input BREADY,
    input ARADDR, ARVALID, output ARREADY,
    output RDATA, RRESP, RVALID, input RREADY
  );
endinterface

// File: rtl/axi_cfg_master.sv
// AXI4-Lite initiator for the config register slave: one command in flight, registered outputs.
// Optional watchdog (sticky timeout_err) enabled by defining AXI_CFG_MASTER_TIMEOUT_EN.
module axi_cfg_master #(
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int C_M_AXI_ADDR_WIDTH = 9,
  parameter int TIMEOUT_CYCLES     = 1024
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            cmd_valid,
  output logic                            cmd_ready,
  input  logic                            cmd_write,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [C_M_AXI_DATA_WIDTH/8-1:0] cmd_wstrb,
  output logic                            rsp_valid,
  input  logic                            rsp_ready,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]                      rsp_resp,
  axi_cfg_master_if.master                M_AXI
`ifdef AXI_CFG_MASTER_TIMEOUT_EN
  ,
  output logic                            timeout_err
`endif
);

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("axi_cfg_master: TIMEOUT_CYCLES must be at least 1");
  end

  typedef enum logic [2:0] {
    IDLE,
    WR_REQ,
    WR_RESP,
    RD_REQ,
    RD_DATA,
    RESP
  } state_t;

  state_t                          state;
  logic [C_M_AXI_ADDR_WIDTH-1:0]   addr_q;
  logic [C_M_AXI_DATA_WIDTH-1:0]   wdata_q;
  logic [C_M_AXI_DATA_WIDTH/8-1:0] wstrb_q;
  logic                            awvalid_q;
  logic                            wvalid_q;
  logic                            bready_q;
  logic                            arvalid_q;
  logic                            rready_q;

`ifdef AXI_CFG_MASTER_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  logic [TMO_W-1:0] tmo_cnt;
`endif

  assign M_AXI.AWADDR  = addr_q;
  assign M_AXI.AWVALID = awvalid_q;
  assign M_AXI.WDATA   = wdata_q;
  assign M_AXI.WSTRB   = wstrb_q;
  assign M_AXI.WVALID  = wvalid_q;
  assign M_AXI.BREADY  = bready_q;
  assign M_AXI.ARADDR  = addr_q;
  assign M_AXI.ARVALID = arvalid_q;
  assign M_AXI.RREADY  = rready_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cmd_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_resp  <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
`ifdef AXI_CFG_MASTER_TIMEOUT_EN
      tmo_cnt     <= '0;
      timeout_err <= 1'b0;
`endif
    end else begin
`ifdef AXI_CFG_MASTER_TIMEOUT_EN
      // Waiting states count; the two wait-to-wait transitions below clear it again.
      if (state == IDLE || state == RESP) tmo_cnt <= '0;
      else if (tmo_cnt == TMO_LAST)       timeout_err <= 1'b1;
      else                                tmo_cnt <= tmo_cnt + TMO_W'(1);
`endif
      case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            cmd_ready <= 1'b0;
            addr_q    <= cmd_addr;
            wdata_q   <= cmd_wdata;
            wstrb_q   <= cmd_wstrb;
            if (cmd_write) begin
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
              state     <= WR_REQ;
            end else begin
              arvalid_q <= 1'b1;
              state     <= RD_REQ;
            end
          end else begin
            cmd_ready <= 1'b1;
          end
        end

        WR_REQ: begin
          // AW and W complete independently; move on once neither is still pending.
          if (M_AXI.AWREADY) awvalid_q <= 1'b0;
          if (M_AXI.WREADY)  wvalid_q  <= 1'b0;
          if ((!awvalid_q || M_AXI.AWREADY) && (!wvalid_q || M_AXI.WREADY)) begin
            bready_q <= 1'b1;
            state    <= WR_RESP;
`ifdef AXI_CFG_MASTER_TIMEOUT_EN
            tmo_cnt  <= '0;
`endif
          end
        end

        WR_RESP: begin
          if (M_AXI.BVALID) begin
            bready_q  <= 1'b0;
            rsp_resp  <= M_AXI.BRESP;
            rsp_rdata <= '0;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end
        end

        RD_REQ: begin
          if (M_AXI.ARREADY) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state     <= RD_DATA;
`ifdef AXI_CFG_MASTER_TIMEOUT_EN
            tmo_cnt   <= '0;
`endif
          end
        end

        RD_DATA: begin
          if (M_AXI.RVALID) begin
            rready_q  <= 1'b0;
            rsp_rdata <= M_AXI.RDATA;
            rsp_resp  <= M_AXI.RRESP;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end
        end

        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_cfg_master.sv
// Bench for axi_cfg_master: negedge-driven AXI-Lite slave with configurable ready delays,
// a response scoreboard and a handshake-rule monitor.
module tb_axi_cfg_master;
  localparam int DW = 32;
  localparam int AW = 9;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cmd_valid = 1'b0;
  logic cmd_ready;
  logic cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic [DW/8-1:0] cmd_wstrb = '0;
  logic rsp_valid;
  logic rsp_ready = 1'b1;
  logic [DW-1:0] rsp_rdata;
  logic [1:0] rsp_resp;
`ifdef AXI_CFG_MASTER_TIMEOUT_EN
  logic timeout_err;
`endif

  always #5 clk = ~clk;

  axi_cfg_master_if #(.C_M_AXI_DATA_WIDTH(DW), .C_M_AXI_ADDR_WIDTH(AW)) bus ();

  axi_cfg_master #(
    .C_M_AXI_DATA_WIDTH(DW),
    .C_M_AXI_ADDR_WIDTH(AW),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_write(cmd_write),
    .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata),
    .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata),
    .rsp_resp(rsp_resp),
    .M_AXI(bus.master)
`ifdef AXI_CFG_MASTER_TIMEOUT_EN
    ,
    .timeout_err(timeout_err)
`endif
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_acc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [DW-1:0] rdata;
    logic [1:0]    resp;
  } exp_t;
  exp_t sb[$];

  logic [DW-1:0] mdl [3];
  logic [DW-1:0] sregs [3];

  int aw_dly = 0, w_dly = 0, ar_dly = 0;
  int aw_cnt = 0, w_cnt = 0, ar_cnt = 0;
  bit aw_got = 0, w_got = 0;
  int b_hs = 0;
  logic [1:0] bresp_cfg = 2'b00, rresp_cfg = 2'b00;
  logic [AW-1:0] s_awaddr, s_araddr;
  logic [DW-1:0] s_wdata;
  logic [DW/8-1:0] s_wstrb;
  bit last_bready = 0, last_rready = 0;
  bit p_awv = 0, p_awr = 0, p_wv = 0, p_wr = 0, p_arv = 0, p_arr = 0;
  logic [AW-1:0] p_awaddr, p_araddr;
  logic [DW-1:0] p_wdata;

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_v, input logic [DW-1:0] new_v,
                                          input logic [DW/8-1:0] strb);
    logic [DW-1:0] r;
    r = old_v;
    for (int b = 0; b < DW/8; b++) if (strb[b]) r[b*8 +: 8] = new_v[b*8 +: 8];
    return r;
  endfunction

  function automatic bit addr_ok(input logic [AW-1:0] a);
    return (a[AW-1:4] == '0) && (a[3:2] != 2'b11) && (a[1:0] == 2'b00);
  endfunction

  // Slave and protocol monitor: ready/valid change only at negedge, sampled by the DUT at posedge.
  always @(negedge clk) begin
    if (rst) begin
      bus.AWREADY = 0; bus.WREADY = 0; bus.ARREADY = 0;
      bus.BVALID = 0; bus.BRESP = '0; bus.RVALID = 0; bus.RRESP = '0; bus.RDATA = '0;
      aw_cnt = 0; w_cnt = 0; ar_cnt = 0; aw_got = 0; w_got = 0;
      last_bready = 0; last_rready = 0;
      p_awv = 0; p_awr = 0; p_wv = 0; p_wr = 0; p_arv = 0; p_arr = 0;
    end else begin
      if (p_awv && !p_awr) begin
        checks++;
        if (bus.AWVALID !== 1'b1 || bus.AWADDR !== p_awaddr) begin
          errors++;
          $display("FAIL aw_hold: AWVALID=%b AWADDR=%h, required 1/%h", bus.AWVALID, bus.AWADDR, p_awaddr);
        end
      end
      if (p_awv && p_awr) begin
        checks++;
        if (bus.AWVALID !== 1'b0) begin
          errors++; $display("FAIL aw_drop: AWVALID=%b after handshake, required 0", bus.AWVALID);
        end
      end
      if (p_wv && !p_wr) begin
        checks++;
        if (bus.WVALID !== 1'b1 || bus.WDATA !== p_wdata) begin
          errors++;
          $display("FAIL w_hold: WVALID=%b WDATA=%h, required 1/%h", bus.WVALID, bus.WDATA, p_wdata);
        end
      end
      if (p_wv && p_wr) begin
        checks++;
        if (bus.WVALID !== 1'b0) begin
          errors++; $display("FAIL w_drop: WVALID=%b after handshake, required 0", bus.WVALID);
        end
      end
      if (p_arv && !p_arr) begin
        checks++;
        if (bus.ARVALID !== 1'b1 || bus.ARADDR !== p_araddr) begin
          errors++;
          $display("FAIL ar_hold: ARVALID=%b ARADDR=%h, required 1/%h", bus.ARVALID, bus.ARADDR, p_araddr);
        end
      end

      if (bus.AWREADY) begin
        bus.AWREADY = 0; aw_got = 1;
      end else if (bus.AWVALID && !aw_got) begin
        if (aw_cnt >= aw_dly) begin bus.AWREADY = 1; s_awaddr = bus.AWADDR; end
        else aw_cnt++;
      end
      if (bus.WREADY) begin
        bus.WREADY = 0; w_got = 1;
      end else if (bus.WVALID && !w_got) begin
        if (w_cnt >= w_dly) begin bus.WREADY = 1; s_wdata = bus.WDATA; s_wstrb = bus.WSTRB; end
        else w_cnt++;
      end
      if (bus.BVALID && last_bready) begin
        bus.BVALID = 0; b_hs++;
      end
      if (aw_got && w_got && !bus.BVALID) begin
        if (addr_ok(s_awaddr)) sregs[s_awaddr[3:2]] = merge(sregs[s_awaddr[3:2]], s_wdata, s_wstrb);
        bus.BVALID = 1; bus.BRESP = bresp_cfg;
        aw_got = 0; w_got = 0; aw_cnt = 0; w_cnt = 0;
      end

      if (bus.RVALID && last_rready) bus.RVALID = 0;
      if (bus.ARREADY) begin
        bus.ARREADY = 0; bus.RVALID = 1; bus.RRESP = rresp_cfg;
        bus.RDATA = addr_ok(s_araddr) ? sregs[s_araddr[3:2]] : '0;
        ar_cnt = 0;
      end else if (bus.ARVALID && !bus.RVALID) begin
        if (ar_cnt >= ar_dly) begin bus.ARREADY = 1; s_araddr = bus.ARADDR; end
        else ar_cnt++;
      end

      p_awv = bus.AWVALID; p_awr = bus.AWREADY; p_awaddr = bus.AWADDR;
      p_wv = bus.WVALID; p_wr = bus.WREADY; p_wdata = bus.WDATA;
      p_arv = bus.ARVALID; p_arr = bus.ARREADY; p_araddr = bus.ARADDR;
      last_bready = bus.BREADY; last_rready = bus.RREADY;
    end
  end

  task automatic send_cmd(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input logic [DW/8-1:0] s);
    exp_t e;
    bit ok;
    if (wr) begin
      e.rdata = '0; e.resp = bresp_cfg;
      if (addr_ok(a)) mdl[a[3:2]] = merge(mdl[a[3:2]], d, s);
    end else begin
      e.rdata = addr_ok(a) ? mdl[a[3:2]] : '0; e.resp = rresp_cfg;
    end
    sb.push_back(e);
    cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s; cmd_valid = 1'b1;
    ok = 0;
    for (int i = 0; i < 50 && !ok; i++) begin
      if (cmd_ready === 1'b1) begin @(posedge clk); ok = 1; end
      else @(negedge clk);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    last_acc = cyc;
    checks++;
    if (!ok) begin
      errors++; $display("FAIL cmd_accept: cmd_ready never seen within 50 cycles, required 1");
    end else begin
      checks++;
      if (wr && (bus.AWVALID !== 1'b1 || bus.WVALID !== 1'b1)) begin
        errors++;
        $display("FAIL req_valid_n1: AWVALID=%b WVALID=%b, required 1/1", bus.AWVALID, bus.WVALID);
      end else if (!wr && bus.ARVALID !== 1'b1) begin
        errors++; $display("FAIL req_valid_n1: ARVALID=%b, required 1", bus.ARVALID);
      end
    end
  endtask

  task automatic get_rsp(input int hold, input string nm);
    exp_t e;
    bit seen;
    seen = 0;
    rsp_ready = (hold == 0);
    for (int i = 0; i < 100 && !seen; i++) begin
      if (rsp_valid === 1'b1) seen = 1;
      else @(negedge clk);
    end
    checks++;
    if (!seen || sb.size() == 0) begin
      errors++;
      $display("FAIL %s_rsp: rsp_valid=%b queued=%0d, required a response", nm, rsp_valid, sb.size());
      if (sb.size() > 0) void'(sb.pop_front());
      rsp_ready = 1'b1;
      return;
    end
    e = sb.pop_front();
    checks++;
    if (rsp_rdata !== e.rdata) begin
      errors++; $display("FAIL %s_rdata: got %h, required %h", nm, rsp_rdata, e.rdata);
    end
    checks++;
    if (rsp_resp !== e.resp) begin
      errors++; $display("FAIL %s_resp: got %b, required %b", nm, rsp_resp, e.resp);
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== e.rdata || rsp_resp !== e.resp) begin
        errors++;
        $display("FAIL %s_hold: valid=%b rdata=%h resp=%b, required 1/%h/%b",
                 nm, rsp_valid, rsp_rdata, rsp_resp, e.rdata, e.resp);
      end
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++; $display("FAIL %s_consume: rsp_valid=%b after handshake, required 0", nm, rsp_valid);
    end
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    checks++;
    if ({cmd_ready, rsp_valid, bus.AWVALID, bus.WVALID, bus.BREADY, bus.ARVALID, bus.RREADY} !== 7'b0) begin
      errors++;
      $display("FAIL reset_ctrl: cmd_ready/rsp_valid/AWV/WV/BR/ARV/RR=%b, required 0000000",
               {cmd_ready, rsp_valid, bus.AWVALID, bus.WVALID, bus.BREADY, bus.ARVALID, bus.RREADY});
    end
    checks++;
    if (rsp_rdata !== '0 || rsp_resp !== 2'b00 || bus.AWADDR !== '0 || bus.WDATA !== '0 || bus.WSTRB !== '0) begin
      errors++;
      $display("FAIL reset_data: rdata=%h resp=%b addr=%h wdata=%h wstrb=%h, required all 0",
               rsp_rdata, rsp_resp, bus.AWADDR, bus.WDATA, bus.WSTRB);
    end
`ifdef AXI_CFG_MASTER_TIMEOUT_EN
    checks++;
    if (timeout_err !== 1'b0) begin
      errors++; $display("FAIL reset_timeout: timeout_err=%b, required 0", timeout_err);
    end
`endif
    #2 rst = 1'b0;
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++; $display("FAIL reset_release: cmd_ready=%b, required 1", cmd_ready);
    end
  endtask

  task automatic test_write_zero_wait;
    int b0;
    b0 = b_hs;
    send_cmd(1, 9'h008, 32'hDEADBEEF, 4'hF);
    get_rsp(0, "wr_zw");
    checks++;
    if (b_hs - b0 != 1) begin
      errors++; $display("FAIL wr_zw_bhs: %0d B handshakes, required 1", b_hs - b0);
    end
    checks++;
    if (sregs[2] !== 32'hDEADBEEF) begin
      errors++; $display("FAIL wr_zw_slave: xadc_config=%h, required deadbeef", sregs[2]);
    end
  endtask

  task automatic test_read_hold;
    send_cmd(0, 9'h008, '0, '0);
    get_rsp(5, "rd_hold");
  endtask

  task automatic test_write_order;
    int b0;
    aw_dly = 3; w_dly = 0;
    b0 = b_hs;
    send_cmd(1, 9'h000, 32'h0000_0002, 4'hF);
    get_rsp(0, "wr_w_first");
    checks++;
    if (b_hs - b0 != 1) begin
      errors++; $display("FAIL wr_w_first_bhs: %0d B handshakes, required 1", b_hs - b0);
    end
    aw_dly = 0; w_dly = 3;
    b0 = b_hs;
    send_cmd(1, 9'h004, 32'h1234_56A5, 4'b0011);
    get_rsp(0, "wr_aw_first");
    checks++;
    if (b_hs - b0 != 1) begin
      errors++; $display("FAIL wr_aw_first_bhs: %0d B handshakes, required 1", b_hs - b0);
    end
    w_dly = 0;
    send_cmd(0, 9'h000, '0, '0);
    get_rsp(0, "rd_char_select");
    send_cmd(0, 9'h004, '0, '0);
    get_rsp(0, "rd_network_out");
  endtask

  task automatic test_error_resp;
    bresp_cfg = 2'b10;
    send_cmd(1, 9'h004, 32'hCAFE_0001, 4'hF);
    get_rsp(0, "wr_slverr");
    bresp_cfg = 2'b00;
    rresp_cfg = 2'b10;
    send_cmd(0, 9'h004, '0, '0);
    get_rsp(0, "rd_slverr");
    rresp_cfg = 2'b00;
  endtask

  task automatic test_back_to_back;
    int acc [3];
    send_cmd(0, 9'h008, '0, '0);     acc[0] = last_acc; get_rsp(0, "b2b_0");
    send_cmd(1, 9'h004, 32'h5A5A_0F0F, 4'hF); acc[1] = last_acc; get_rsp(0, "b2b_1");
    send_cmd(0, 9'h004, '0, '0);     acc[2] = last_acc; get_rsp(0, "b2b_2");
    for (int i = 1; i < 3; i++) begin
      checks++;
      if (acc[i] - acc[i-1] != 4) begin
        errors++; $display("FAIL b2b_spacing%0d: %0d cycles, required 4", i, acc[i] - acc[i-1]);
      end
    end
  endtask

  task automatic test_reset_mid;
    ar_dly = 100;
    send_cmd(0, 9'h000, '0, '0);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({bus.ARVALID, bus.RREADY, bus.AWVALID, bus.WVALID, bus.BREADY, cmd_ready, rsp_valid} !== 7'b0) begin
      errors++;
      $display("FAIL rst_mid: ARV/RR/AWV/WV/BR/cmd_ready/rsp_valid=%b, required 0000000",
               {bus.ARVALID, bus.RREADY, bus.AWVALID, bus.WVALID, bus.BREADY, cmd_ready, rsp_valid});
    end
    sb.delete();
    @(negedge clk);
    ar_dly = 0;
    #2 rst = 1'b0;
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1 || bus.ARVALID !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_release: cmd_ready=%b ARVALID=%b, required 1/0", cmd_ready, bus.ARVALID);
    end
    send_cmd(0, 9'h008, '0, '0);
    get_rsp(0, "rd_after_rst");
  endtask

`ifdef AXI_CFG_MASTER_TIMEOUT_EN
  task automatic test_timeout;
    int hi;
    bit hit;
    ar_dly = 20;
    send_cmd(0, 9'h008, '0, '0);
    hi = (timeout_err === 1'b0) ? 1 : 0;
    hit = 0;
    for (int i = 0; i < 40 && !hit; i++) begin
      @(negedge clk);
      if (timeout_err === 1'b1) hit = 1;
      else hi++;
    end
    checks++;
    if (!hit || hi != 16) begin
      errors++; $display("FAIL timeout_cycle: set=%b after %0d waiting cycles, required 1 after 16", hit, hi);
    end
    checks++;
    if (bus.ARVALID !== 1'b1) begin
      errors++; $display("FAIL timeout_arvalid: ARVALID=%b at timeout, required 1", bus.ARVALID);
    end
    get_rsp(0, "rd_timeout");
    checks++;
    if (timeout_err !== 1'b1) begin
      errors++; $display("FAIL timeout_sticky: timeout_err=%b, required 1", timeout_err);
    end
    ar_dly = 0;
  endtask
`endif

  initial begin
    for (int i = 0; i < 3; i++) begin mdl[i] = '0; sregs[i] = '0; end
    bus.AWREADY = 0; bus.WREADY = 0; bus.ARREADY = 0;
    bus.BVALID = 0; bus.BRESP = '0; bus.RVALID = 0; bus.RRESP = '0; bus.RDATA = '0;
    test_reset;
    test_write_zero_wait;
    test_read_hold;
    test_write_order;
    test_error_resp;
    test_back_to_back;
    test_reset_mid;
`ifdef AXI_CFG_MASTER_TIMEOUT_EN
    test_timeout;
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within 200000 time units");
    $fatal(1);
  end
endmodule
